// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and constants for the FIFO-draining UART transmitter.
// The optional parity stage is enabled with FIFO_UART_TX_PARITY_EN.
package fifo_uart_pkg;

    typedef enum logic [2:0] {IDLE, FETCH, START, DATA, PARITY, STOP} tx_state_t;

    localparam int   DEFAULT_CLKS_PER_BIT = 434;
    localparam logic IDLE_LEVEL           = 1'b1;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read port as seen by a consumer.
// Read protocol: the master raises fifo_rd_en for one cycle only while fifo_empty is low;
// the slave presents the popped word on fifo_data the following cycle.
interface fifo_uart_tx_if #(
    parameter int DATA_BITS = 8
);
    logic                 fifo_rd_en;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_data;

    modport master (output fifo_rd_en, input fifo_empty, input fifo_data);
    modport slave  (input fifo_rd_en, output fifo_empty, output fifo_data);
endinterface

// File: rtl/fifo_uart_tx_baud_gen.sv
// Bit-period timer: bit_tick marks the last clock of each bit; restart holds the count at zero.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic bit_tick
);
    localparam int              CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] baud_cnt;

    assign bit_tick = !restart && (baud_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= '0;
        end else if (restart || bit_tick) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a registered-output FIFO one word per frame and serializes it as start/data/stop on tx.
// Defining FIFO_UART_TX_PARITY_EN inserts an even-parity bit between data and stop.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tx_en,
    fifo_uart_tx_if.master        fifo,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done,
    output tx_state_t             state
);
    localparam int            BW        = $clog2(DATA_BITS) + 1;
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    tx_state_t            state_next;
    logic [DATA_BITS-1:0] shift_q, shift_next;
    logic [BW-1:0]        bit_cnt, bit_cnt_next;
    logic                 tx_next;
    logic                 bit_tick;
    logic                 baud_restart;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                 parity_q, parity_next;
`endif

    uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart  (baud_restart),
        .bit_tick (bit_tick)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shift_q  <= '0;
            bit_cnt  <= '0;
            tx       <= IDLE_LEVEL;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state    <= state_next;
            shift_q  <= shift_next;
            bit_cnt  <= bit_cnt_next;
            tx       <= tx_next;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q <= parity_next;
`endif
        end
    end

    // tx_next is the line level for the state being entered, so tx changes on the same edge as state.
    always_comb begin
        state_next      = state;
        shift_next      = shift_q;
        bit_cnt_next    = bit_cnt;
        tx_next         = tx;
        baud_restart    = 1'b0;
        frame_done      = 1'b0;
        fifo.fifo_rd_en = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_next     = parity_q;
`endif
        case (state)
            IDLE: begin
                baud_restart = 1'b1;
                tx_next      = IDLE_LEVEL;
                if (tx_en && !fifo.fifo_empty) begin
                    fifo.fifo_rd_en = 1'b1;
                    state_next      = FETCH;
                end
            end
            FETCH: begin
                baud_restart = 1'b1;
                shift_next   = fifo.fifo_data;
                bit_cnt_next = '0;
                tx_next      = ~IDLE_LEVEL;
                state_next   = START;
`ifdef FIFO_UART_TX_PARITY_EN
                parity_next  = ^fifo.fifo_data;
`endif
            end
            START: begin
                if (bit_tick) begin
                    state_next = DATA;
                    tx_next    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_tick) begin
                    shift_next = shift_q >> 1;
                    if (bit_cnt == LAST_DATA) begin
                        bit_cnt_next = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                        state_next   = PARITY;
                        tx_next      = parity_q;
`else
                        state_next   = STOP;
                        tx_next      = IDLE_LEVEL;
`endif
                    end else begin
                        bit_cnt_next = bit_cnt + 1'b1;
                        tx_next      = shift_q[1];
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
                if (bit_tick) begin
                    state_next = STOP;
                    tx_next    = IDLE_LEVEL;
                end
            end
`endif
            STOP: begin
                if (bit_tick) begin
                    if (bit_cnt == LAST_STOP) begin
                        frame_done   = 1'b1;
                        bit_cnt_next = '0;
                        state_next   = IDLE;
                    end else begin
                        bit_cnt_next = bit_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = IDLE_LEVEL;
            end
        endcase
    end
endmodule
